sort_result_streamer: RTL

- Output-side companion of the 32-input odd-even merge sorter.
- Captures one full parallel sorted frame of 29-bit records in a single cycle.
- Streams the frame out one record per beat over a valid/ready interface to downstream image-processing logic.
- Decouples the combinational sorter from any consumer that cannot take 32 records at once.

---
 rtl/sort_pkg.sv | 34 +++
 rtl/frame_buffer_mux.sv | 56 +++++
 rtl/sort_result_streamer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sorter output path.
// Holds the record and frame geometry, the record field offsets and the
// streamer FSM state encoding. There are no ports. Other files pull these in
// with "import sort_pkg::*".
package sort_pkg;

    // Frame geometry of the 32-input odd-even merge sorter.
    localparam int REC_W   = 29;
    localparam int FRAME_N = 32;

    // Beat counter width. It covers beat numbers 0..31 and never wraps.
    localparam int CNT_W = 5;

    // Record field layout: [28:24] id, [23:22] class, [21:16] count,
    // [15:8] key_hi, [7:0] key_lo. The streamer passes records through
    // untouched, so these offsets are here only for downstream users.
    localparam int ID_LSB    = 24;
    localparam int CLASS_LSB = 22;
    localparam int CNT_LSB   = 16;
    localparam int KEYHI_LSB = 8;

    // Streamer control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_e;

    // Beat number of the final record in a frame of n records.
    function automatic logic [CNT_W-1:0] last_beat(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/frame_buffer_mux.sv
// Frame buffer for the sort result streamer.
// Stores one full sorted frame of N records, each W bits wide. The frame is
// written in one cycle when load is high. A single read port returns the
// record for output beat rd_idx. When DESCENDING is set, beat 0 maps to slot
// N-1, so the reversal happens here and the controller only counts upward.
// Ports:
//   clk      - rising-edge clock
//   load     - capture frame_in into the buffer on this edge
//   frame_in - N packed records; slot i sits at [i*W +: W]
//   rd_idx   - output beat number to read
//   rd_data  - record for that beat, combinational from the buffer
module frame_buffer_mux
    import sort_pkg::*;
#(
    parameter int N          = FRAME_N,
    parameter int W          = REC_W,
    parameter bit DESCENDING = 1'b0
) (
    input  logic             clk,
    input  logic             load,
    input  logic [N*W-1:0]   frame_in,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data
);

    localparam logic [CNT_W-1:0] LAST_IDX = last_beat(N);

    logic [W-1:0]     mem_q [N];
    logic [W-1:0]     mem_d [N];
    logic [CNT_W-1:0] phys_idx;

    // The buffer is reloaded only when a new frame is captured. Between
    // captures it holds its contents, so the streamed data cannot change in
    // the middle of a frame.
    always_comb begin
        mem_d = mem_q;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                mem_d[i] = frame_in[i*W +: W];
            end
        end
    end

    // The contents only matter after a capture, so the buffer has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // In a descending build, beat k reads slot N-1-k.
    always_comb begin
        phys_idx = DESCENDING ? (LAST_IDX - rd_idx) : rd_idx;
    end

    assign rd_data = mem_q[phys_idx];

endmodule

// File: rtl/sort_result_streamer.sv
// Sort result streamer.
// Captures one parallel sorted frame from the merge sorter in a single cycle.
// It then sends the frame out one record per beat on a valid/ready stream.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   in_valid    - sorted frame present on in_frame
//   in_ready    - streamer is idle and will capture a frame this cycle
//   in_frame    - N packed sorted records; slot i at [i*W +: W]
//   out_valid   - out_data holds a record; held until accepted
//   out_ready   - consumer accepts the current record
//   out_data    - current record, bit-exact copy of a sorter slot
//   out_rank    - beat number of the current record, 0..N-1
//   out_last    - current record is the final beat of the frame
//   frame_done  - one-cycle pulse after the final beat is accepted
//   overrun     - sticky: a frame was offered while the streamer was busy
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int N          = FRAME_N,
    parameter int W          = REC_W,
    parameter bit DESCENDING = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_frame,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_rank,
    output logic             out_last,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = last_beat(N);

    stream_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             buf_load;
    logic             is_last;
    logic [W-1:0]     rd_data;

    frame_buffer_mux #(
        .N          (N),
        .W          (W),
        .DESCENDING (DESCENDING)
    ) u_buf (
        .clk      (clk),
        .load     (buf_load),
        .frame_in (in_frame),
        .rd_idx   (count_q),
        .rd_data  (rd_data)
    );

    assign is_last = (count_q == LAST_IDX);

    // Next-state logic.
    // A frame is captured only in IDLE. In STREAM the beat counter advances on
    // each accepted beat. Accepting the final beat moves the FSM to DONE for
    // exactly one cycle. A frame offered in STREAM or DONE is dropped and sets
    // the sticky overrun flag. The status outputs are computed from the next
    // state so that they can be registered.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        buf_load     = 1'b0;
        in_ready_d   = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_load = 1'b1;
                    count_d  = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (is_last) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase

        if (in_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        in_ready_d   = (state_d == IDLE);
        out_valid_d  = (state_d == STREAM);
        frame_done_d = (state_d == DONE);
    end

    // State and status registers. Reset abandons any frame in flight and
    // clears the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // out_data is forced to zero outside STREAM. This keeps buffer contents
    // hidden when no record is valid, including right after reset.
    assign out_data   = out_valid_q ? rd_data : '0;
    assign out_last   = out_valid_q && is_last;
    assign out_rank   = count_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
